// File: rtl/kb_field_entry_ctrl.sv
// Keyboard-driven entry controller: pops PS/2 scan codes, filters break/extended
// prefixes, and turns digit keys into one range-checked write per committed field.
module kb_field_entry_ctrl #(
    parameter int TIMEOUT_CYCLES = 250000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  kb_data,
    input  logic        kb_ready,
    output logic        kb_nextdata_n,
    output logic [3:0]  cur_field,
    output logic        entry_active,
    output logic [2:0]  digit_count,
    output logic [13:0] entry_value,
    output logic        wr_en,
    output logic [3:0]  wr_field,
    output logic [13:0] wr_data,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] C_BRK   = 8'hF0;
    localparam logic [7:0] C_EXT   = 8'hE0;
    localparam logic [7:0] C_ENTER = 8'h5A;
    localparam logic [7:0] C_ESC   = 8'h76;
    localparam logic [7:0] C_BS    = 8'h66;
    localparam logic [7:0] C_TAB   = 8'h0D;

    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_COMMIT} state_t;

    state_t          state;
    logic [7:0]      byte_q;
    logic            byte_vld;
    logic            brk;
    logic            ext;
    logic [15:0]     digits;
    logic [TW-1:0]   tmo_cnt;

    logic            key_vld;
    logic            is_digit;
    logic [3:0]      digit_val;
    logic            is_enter;
    logic            is_esc;
    logic            is_bs;
    logic            is_tab;
    logic            in_range;
    logic [2:0]      max_digits;

    // A byte is a key only when it is neither a prefix nor a release code; after
    // E0 only the keypad Enter survives.
    always_comb begin
        key_vld = 1'b0;
        if (byte_vld && byte_q != C_BRK && byte_q != C_EXT && !brk) begin
            key_vld = !ext || (byte_q == C_ENTER);
        end
    end

    always_comb begin
        is_digit  = 1'b1;
        digit_val = 4'd0;
        case (byte_q)
            8'h45, 8'h70: digit_val = 4'd0;
            8'h16, 8'h69: digit_val = 4'd1;
            8'h1E, 8'h72: digit_val = 4'd2;
            8'h26, 8'h7A: digit_val = 4'd3;
            8'h25, 8'h6B: digit_val = 4'd4;
            8'h2E, 8'h73: digit_val = 4'd5;
            8'h36, 8'h74: digit_val = 4'd6;
            8'h3D, 8'h6C: digit_val = 4'd7;
            8'h3E, 8'h75: digit_val = 4'd8;
            8'h46, 8'h7D: digit_val = 4'd9;
            default:      is_digit  = 1'b0;
        endcase
        is_digit = is_digit && key_vld;
        is_enter = key_vld && (byte_q == C_ENTER);
        is_esc   = key_vld && (byte_q == C_ESC);
        is_bs    = key_vld && (byte_q == C_BS);
        is_tab   = key_vld && (byte_q == C_TAB);
    end

    assign entry_value = 14'(digits[15:12]) * 14'd1000 + 14'(digits[11:8]) * 14'd100 +
                         14'(digits[7:4]) * 14'd10 + 14'(digits[3:0]);

    assign max_digits = (cur_field == 4'd0) ? 3'd4 : 3'd2;

    always_comb begin
        case (cur_field)
            4'd0:       in_range = 1'b1;
            4'd1:       in_range = (entry_value >= 14'd1) && (entry_value <= 14'd12);
            4'd2:       in_range = (entry_value >= 14'd1) && (entry_value <= 14'd31);
            4'd3, 4'd6: in_range = (entry_value <= 14'd23);
            default:    in_range = (entry_value <= 14'd59);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            byte_q        <= 8'd0;
            byte_vld      <= 1'b0;
            brk           <= 1'b0;
            ext           <= 1'b0;
            digits        <= 16'd0;
            tmo_cnt       <= '0;
            kb_nextdata_n <= 1'b1;
            cur_field     <= 4'd0;
            entry_active  <= 1'b0;
            digit_count   <= 3'd0;
            wr_en         <= 1'b0;
            wr_field      <= 4'd0;
            wr_data       <= 14'd0;
            err           <= 1'b0;
            err_code      <= 2'd0;
        end else begin
            kb_nextdata_n <= 1'b1;
            byte_vld      <= 1'b0;
            wr_en         <= 1'b0;
            err           <= 1'b0;

            // A low kb_nextdata_n doubles as the one-cycle holdoff while the
            // receiver updates kb_ready after the pop.
            if (kb_ready && kb_nextdata_n && state != S_COMMIT) begin
                byte_q        <= kb_data;
                byte_vld      <= 1'b1;
                kb_nextdata_n <= 1'b0;
            end

            if (byte_vld) begin
                if (byte_q == C_BRK) begin
                    brk <= 1'b1;
                end else if (byte_q == C_EXT) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                end
            end

            case (state)
                S_IDLE: begin
                    if (is_tab) begin
                        cur_field <= (cur_field == 4'd8) ? 4'd0 : cur_field + 4'd1;
                    end else if (is_enter) begin
                        state        <= S_ENTRY;
                        entry_active <= 1'b1;
                        digits       <= 16'd0;
                        digit_count  <= 3'd0;
                        tmo_cnt      <= '0;
                    end
                end
                S_ENTRY: begin
                    if (key_vld) begin
                        tmo_cnt <= '0;
                        if (is_digit) begin
                            if (digit_count < max_digits) begin
                                digits      <= {digits[11:0], digit_val};
                                digit_count <= digit_count + 3'd1;
                            end else begin
                                err      <= 1'b1;
                                err_code <= 2'd1;
                            end
                        end else if (is_bs) begin
                            if (digit_count != 3'd0) begin
                                digits      <= {4'd0, digits[15:4]};
                                digit_count <= digit_count - 3'd1;
                            end
                        end else if (is_esc || (is_enter && digit_count == 3'd0)) begin
                            state        <= S_IDLE;
                            entry_active <= 1'b0;
                            digits       <= 16'd0;
                            digit_count  <= 3'd0;
                        end else if (is_enter) begin
                            state        <= S_COMMIT;
                            entry_active <= 1'b0;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state        <= S_IDLE;
                        entry_active <= 1'b0;
                        digits       <= 16'd0;
                        digit_count  <= 3'd0;
                        err          <= 1'b1;
                        err_code     <= 2'd3;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_COMMIT: begin
                    if (in_range) begin
                        wr_en    <= 1'b1;
                        wr_field <= cur_field;
                        wr_data  <= entry_value;
                    end else begin
                        err      <= 1'b1;
                        err_code <= 2'd2;
                    end
                    state       <= S_IDLE;
                    digits      <= 16'd0;
                    digit_count <= 3'd0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kb_field_entry_ctrl.sv
// Bench for kb_field_entry_ctrl: a PS/2 byte queue feeds the DUT, a key-level
// model predicts writes/errors into queues, and a monitor pops them on strobes.
module tb_kb_field_entry_ctrl;

    localparam int TMO = 100;
    localparam int K_DIG = 0, K_ENT = 1, K_ESC = 2, K_BS = 3, K_TAB = 4, K_OTH = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  kb_data = 8'd0;
    logic        kb_ready = 1'b0;
    logic        kb_nextdata_n;
    logic [3:0]  cur_field;
    logic        entry_active;
    logic [2:0]  digit_count;
    logic [13:0] entry_value;
    logic        wr_en;
    logic [3:0]  wr_field;
    logic [13:0] wr_data;
    logic        err;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    kb_field_entry_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .kb_data(kb_data), .kb_ready(kb_ready),
        .kb_nextdata_n(kb_nextdata_n), .cur_field(cur_field), .entry_active(entry_active),
        .digit_count(digit_count), .entry_value(entry_value), .wr_en(wr_en),
        .wr_field(wr_field), .wr_data(wr_data), .err(err), .err_code(err_code)
    );

    int checks = 0;
    int failures = 0;
    int bytes_sent = 0;
    int pops = 0;
    logic [7:0]  byte_q[$];
    logic [17:0] exp_q[$];
    logic [1:0]  err_q[$];

    int m_field = 0;
    bit m_entry = 1'b0;
    int m_digits[$];
    int m_err_code = 0;
    int lo[9] = '{0, 1, 1, 0, 0, 0, 0, 0, 0};
    int hi[9] = '{9999, 12, 31, 23, 59, 59, 23, 59, 59};
    logic [7:0] main_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] kp_codes[10]   = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int m_value();
        int v = 0;
        foreach (m_digits[i]) v = v * 10 + m_digits[i];
        return v;
    endfunction

    // Key-level reference: what one key press means for field, entry and digits.
    task automatic model_key(input int k, input int d);
        int v;
        if (!m_entry) begin
            if (k == K_TAB) m_field = (m_field + 1) % 9;
            else if (k == K_ENT) begin
                m_entry = 1'b1;
                m_digits.delete();
            end
        end else begin
            case (k)
                K_DIG: begin
                    if (m_digits.size() < ((m_field == 0) ? 4 : 2)) m_digits.push_back(d);
                    else begin
                        err_q.push_back(2'd1);
                        m_err_code = 1;
                    end
                end
                K_BS: if (m_digits.size() > 0) void'(m_digits.pop_back());
                K_ESC: begin
                    m_entry = 1'b0;
                    m_digits.delete();
                end
                K_ENT: begin
                    if (m_digits.size() > 0) begin
                        v = m_value();
                        if (v >= lo[m_field] && v <= hi[m_field]) exp_q.push_back({4'(m_field), 14'(v)});
                        else begin
                            err_q.push_back(2'd2);
                            m_err_code = 2;
                        end
                    end
                    m_entry = 1'b0;
                    m_digits.delete();
                end
                default: ;
            endcase
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        byte_q.push_back(b);
        bytes_sent++;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (byte_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", byte_q.size(), 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_state();
        check("cur_field", cur_field, m_field);
        check("entry_active", entry_active, m_entry);
        check("digit_count", digit_count, m_digits.size());
        check("entry_value", entry_value, m_value());
        check("err_code_held", err_code, m_err_code);
    endtask

    task automatic check_reset_values();
        check("rst_nextdata_n", kb_nextdata_n, 1);
        check("rst_cur_field", cur_field, 0);
        check("rst_entry_active", entry_active, 0);
        check("rst_digit_count", digit_count, 0);
        check("rst_entry_value", entry_value, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_field", wr_field, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_err", err, 0);
        check("rst_err_code", err_code, 0);
    endtask

    task automatic send_key(input int k, input int d, input bit kp, input bit ext_ent,
                            input bit rel, input bit rpt);
        logic [7:0] code;
        bit use_ext;
        case (k)
            K_DIG:   code = kp ? kp_codes[d] : main_codes[d];
            K_ENT:   code = 8'h5A;
            K_ESC:   code = 8'h76;
            K_BS:    code = 8'h66;
            K_TAB:   code = 8'h0D;
            default: code = 8'h1C;
        endcase
        use_ext = ext_ent && (k == K_ENT);
        for (int i = 0; i < (rpt ? 2 : 1); i++) begin
            model_key(k, d);
            if (use_ext) push_byte(8'hE0);
            push_byte(code);
        end
        if (rel) begin
            if (use_ext) push_byte(8'hE0);
            push_byte(8'hF0);
            push_byte(code);
        end
        wait_drain();
        check_state();
    endtask

    task automatic key(input int k, input int d);
        send_key(k, d, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // PS/2 receiver: pops on a sampled low kb_nextdata_n, then presents the next byte.
    initial begin
        bit prev_low = 1'b0;
        forever begin
            @(negedge clk);
            if (!kb_nextdata_n) begin
                checks++;
                if (prev_low) begin
                    failures++;
                    $display("FAIL pop_holdoff: nextdata_n low 2 cycles, required 1");
                end
                if (byte_q.size() == 0) begin
                    failures++;
                    $display("FAIL pop_empty: pop with 0 bytes queued, required >=1");
                end else begin
                    void'(byte_q.pop_front());
                    pops++;
                end
                prev_low = 1'b1;
            end else begin
                prev_low = 1'b0;
            end
            kb_ready = (byte_q.size() != 0);
            kb_data  = (byte_q.size() != 0) ? byte_q[0] : 8'd0;
        end
    end

    // Monitor: every strobe must match the oldest prediction.
    initial begin
        logic [17:0] e;
        logic [1:0]  ec;
        forever begin
            @(negedge clk);
            if (!rst && wr_en) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected: field %0d data %0d, required no write", wr_field, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_field", wr_field, e[17:14]);
                    check("wr_data", wr_data, e[13:0]);
                end
            end
            if (!rst && err) begin
                if (err_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL err_unexpected: code %0d, required no err", err_code);
                end else begin
                    ec = err_q.pop_front();
                    check("err_code", err_code, ec);
                end
            end
        end
    end

    initial begin
        #900000;
        failures++;
        $display("FAIL watchdog: run exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);

        key(K_TAB, 0);
        key(K_TAB, 0);
        for (int i = 0; i < 7; i++) key(K_TAB, 0);

        key(K_ENT, 0);
        key(K_DIG, 2); key(K_DIG, 0); key(K_DIG, 2); key(K_DIG, 4);
        key(K_ENT, 0);

        key(K_TAB, 0);
        key(K_ENT, 0);
        send_key(K_DIG, 1, 1'b1, 1'b0, 1'b1, 1'b0);
        send_key(K_DIG, 3, 1'b1, 1'b0, 1'b1, 1'b0);
        key(K_ENT, 0);
        key(K_ENT, 0); key(K_DIG, 1); key(K_BS, 0); key(K_DIG, 9); key(K_ENT, 0);

        key(K_TAB, 0); key(K_TAB, 0);
        key(K_ENT, 0); key(K_DIG, 1); key(K_DIG, 2); key(K_DIG, 5);
        key(K_ENT, 0);
        key(K_ENT, 0); key(K_DIG, 4); key(K_ESC, 0);
        key(K_ENT, 0); key(K_ENT, 0);

        key(K_ENT, 0); key(K_DIG, 7);
        err_q.push_back(2'd3);
        repeat (90) @(negedge clk);
        check("tmo_not_early", entry_active, 1);
        repeat (20) @(negedge clk);
        m_entry = 1'b0;
        m_digits.delete();
        m_err_code = 3;
        check_state();

        key(K_ENT, 0); key(K_DIG, 7);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        m_field = 0; m_entry = 1'b0; m_digits.delete(); m_err_code = 0;
        @(negedge clk);

        send_key(K_ENT, 0, 1'b0, 1'b1, 1'b1, 1'b0);
        push_byte(8'hE0); push_byte(8'h75);
        wait_drain(); check_state();
        push_byte(8'hF0); push_byte(8'h45);
        wait_drain(); check_state();
        key(K_DIG, 3); key(K_OTH, 0); key(K_ESC, 0);

        for (int n = 0; n < 250; n++) begin
            int r, k;
            r = $urandom_range(0, 99);
            if (r < 50) k = K_DIG;
            else if (r < 64) k = K_ENT;
            else if (r < 71) k = K_BS;
            else if (r < 75) k = K_ESC;
            else if (r < 90) k = K_TAB;
            else k = K_OTH;
            send_key(k, $urandom_range(0, 9), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0));
        end

        repeat (10) @(negedge clk);
        check("writes_left", exp_q.size(), 0);
        check("errs_left", err_q.size(), 0);
        check("pops_total", pops, bytes_sent);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/kb_field_entry_ctrl.md
Name: kb_field_entry_ctrl

Overview:
- Controller between the PS/2 receiver (`ps2_keyboard`-style: byte output, `ready`, active-low `nextdata_n` pop) and the date/clock/alarm setting registers.
- Pops scan codes and filters break/extended prefixes.
- Sequences selection of one of nine target fields, collects decimal digits, range-checks them, and issues a single write strobe per committed entry.
- Replaces the free-running per-field digit flags with one arbitrated entry path.

Parameters:
- TIMEOUT_CYCLES, 250000000, idle cycles in ENTRY before the entry is aborted (5 s at 50 MHz).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- kb_data  in  8  scan-code byte from the PS/2 receiver
- kb_ready  in  1  receiver has a byte available
- kb_nextdata_n  out  1  active-low pop, one-cycle pulse
- cur_field  out  4  selected field: 0 year, 1 month, 2 day, 3 clk hour, 4 clk min, 5 clk sec, 6 alm hour, 7 alm min, 8 alm sec
- entry_active  out  1  high in ENTRY
- digit_count  out  3  digits collected (0..4)
- entry_value  out  14  binary value of the collected digits (live preview)
- wr_en  out  1  one-cycle commit strobe
- wr_field  out  4  field id accompanying wr_en
- wr_data  out  14  committed value (zero-extended)
- err  out  1  one-cycle error pulse
- err_code  out  2  1 = too many digits, 2 = out of range, 3 = timeout; held until the next err

Behaviour:
- Synchronous reset, and rst has priority over every other event:
  - outputs: kb_nextdata_n=1, cur_field=0, wr_en=0, wr_field=0, wr_data=0, err=0, err_code=0, entry_active=0, digit_count=0, entry_value=0.
  - internal: state=IDLE, digit registers=0, brk/ext flags=0, timeout counter=0.
  - Reset mid-entry discards the digits; no write is issued.
- Pop handshake:
  - If kb_ready=1 at edge t and no holdoff is active, the byte is latched at t and kb_nextdata_n=0 during cycle t..t+1 only.
  - Holdoff: kb_ready is ignored at edge t+1; the next byte can be accepted at t+2 at the earliest.
- Prefix filter (applied before the FSM):
  - F0: set brk. Discard the next byte (the release code) and clear brk.
  - E0: set ext. The next byte is a key only if it is 5A (keypad Enter = Enter); otherwise it is discarded. Clear ext either way.
  - F0 following E0: ext remains set until the released byte is consumed.
  - Typematic repeat make codes count as new presses.
- Key map:
  - Digits 0-9, main row: 45, 16, 1E, 26, 25, 2E, 36, 3D, 3E, 46.
  - Digits 0-9, keypad: 70, 69, 72, 7A, 6B, 73, 74, 6C, 75, 7D.
  - Enter 5A, Esc 76, Backspace 66, Tab 0D.
  - Any other code is ignored.
- FSM states: IDLE, ENTRY, COMMIT.
- IDLE:
  - Tab: cur_field advances by one; 8 wraps to 0.
  - Enter: go to ENTRY; clear digits; clear timeout counter.
  - Digits, Esc, Backspace: ignored.
- ENTRY:
  - Digit: if digit_count < MAXD, shift into the BCD digit register; digit_count+1.
  - MAXD is 4 for field 0 and 2 for all other fields.
  - Digit when digit_count = MAXD: digit dropped; err pulse with code 1; stay in ENTRY.
  - Backspace: drop the last digit, digit_count-1. Ignored at 0 digits.
  - Esc: go to IDLE with no write.
  - Tab: ignored.
  - Enter with 0 digits: go to IDLE with no write and no err.
  - Enter with ≥1 digit: go to COMMIT.
  - Each accepted key clears the timeout counter. When the counter reaches TIMEOUT_CYCLES-1: go to IDLE, err pulse with code 3, no write.
- entry_value is the combinational BCD-to-binary value of the collected digits, e.g. "2","0","2","4" gives 2024.
- Field ranges: year 0..9999, month 1..12, day 1..31, hour 0..23, min/sec 0..59.
- COMMIT (one cycle):
  - Value in range: wr_en=1 for one cycle with wr_field=cur_field and wr_data=entry_value.
  - Value out of range: err pulse with code 2 and no wr_en.
  - Either way, go to IDLE and clear the digits.
  - Latency: wr_en is high in the cycle beginning 2 edges after the edge at which the Enter byte is accepted.
- While in COMMIT, no new byte is accepted; the pop logic waits.
- wr_field and wr_data hold their values after the strobe until the next commit.

Test Plan:
- Reset, then Tab,Tab (each as make 0D + F0 0D) → cur_field=2; each byte produces exactly one kb_nextdata_n low cycle, separated by ≥1 holdoff cycle.
- cur_field=0, Enter, 2,0,2,4, Enter → single wr_en with wr_field=0, wr_data=2024; digit_count returns to 0; entry_active returns to 0.
- cur_field=1, Enter, keypad 1 (69), 3 (7A), Enter → no wr_en; err with err_code=2. Then Enter,1,Backspace,9,Enter → wr_data=9.
- cur_field=3, Enter, 1,2,5 → third digit gives err with code 1 and digit_count stays 2; Enter → wr_data=12. Then Enter,4,Esc → no write.
- TIMEOUT_CYCLES=100, Enter, 7, then no input for 100 cycles → err with err_code=3, entry_active=0, no wr_en. Repeat with rst asserted mid-entry → all outputs at reset values, no wr_en.
- E0 5A (keypad Enter) in IDLE → ENTRY; E0 75 and F0 45 bytes → ignored, no digit change.
